freq_counter: RTL and testbench
===============================

# freq_counter

Measures period and duty of a digital square wave in units of the system clock. It sits downstream of the light-level-to-frequency generator (frequency_module) and recovers the high time, low time and period of its output. It publishes one result per input period, flagged by a one-cycle strobe. All logic runs in the single system clock domain; FREQ_IN is asynchronous to it.

## Interface
- `WIDTH`, 32, width of all count outputs and internal counters.
- `CLK`  input  1  system clock; all state updates on rising edge.
- `RST_N`  input  1  reset. Asynchronous and active-low: assertion clears all state immediately; release is sampled on the CLK rising edge.
- `FREQ_IN`  input  1  square wave to measure; asynchronous to CLK.
- `TIME_HIGH`  output  WIDTH  CLK cycles the input spent high in the last complete period.
- `TIME_LOW`  output  WIDTH  CLK cycles the input spent low in the last complete period.
- `PERIOD`  output  WIDTH  TIME_HIGH + TIME_LOW of the same period.
- `PULSE`  output  1  one-cycle strobe; new TIME_HIGH/TIME_LOW/PERIOD are valid in the same cycle.

## Operation
- Sampled signal `s`: FREQ_IN through the input stage (see Configuration). `s_d` is `s` delayed one cycle. Rising edge `rise = s & ~s_d`.
- `hi_cnt` increments each cycle `s`=1. `lo_cnt` increments each cycle `s`=0. Both saturate at 2^WIDTH−1 and never wrap.
- On a `rise` cycle:
  - `hi_cnt` loads 1, counting the edge cycle itself.
  - `lo_cnt` loads 0.
  - If `armed`=1: `TIME_HIGH` <= `hi_cnt`, `TIME_LOW` <= `lo_cnt`, `PERIOD` <= saturating sum (WIDTH+1-bit add, clamp to all-ones), and `PULSE` <= 1.
  - `armed` <= 1.
- First `rise` after reset only arms the block: no PULSE, outputs stay 0. The partial period before it is discarded.
- Falling edges need no special action; counting simply switches from `hi_cnt` to `lo_cnt`.
- Square wave with H high / L low sampled cycles: each PULSE reports TIME_HIGH=H, TIME_LOW=L, PERIOD=H+L.
- Constant input: no PULSE. Outputs hold the last result. The active counter saturates.
- Changing input frequency: the first PULSE after the change may report a mixed period. The second PULSE after the change reports the new period exactly.

## Timing
- Reset values: TIME_HIGH=TIME_LOW=PERIOD=0, PULSE=0, counters=0, armed=0, synchronizer and `s_d` flops=0.
- PULSE is high for exactly one CLK cycle per rising edge of `s`. It never stays asserted on consecutive cycles; a rise needs at least one low cycle before it.
- Output registers change only on PULSE cycles and hold otherwise.
- Latency with synchronizer: FREQ_IN first sampled high at edge k gives PULSE and new outputs visible after edge k+2.
- Latency without synchronizer: PULSE and new outputs visible after edge k+1.
- Minimum measurable phase is 1 CLK cycle. Shorter input phases may be missed, and the result is then merged into the neighbouring phase.
- RST_N asserted mid-period: everything clears at once, and the block must re-arm on a fresh rising edge.

## Configuration
- `FREQ_COUNTER_SYNC_EN` defined: FREQ_IN passes through a 2-flop synchronizer before `s`. Use this for asynchronous sources.
- Not defined: `s` is FREQ_IN registered once, so latency is one cycle shorter. Use this only when FREQ_IN is generated in the CLK domain.
- Counts (H, L) are identical in both builds; only latency differs.

## Test plan
- Reset: hold RST_N=0 for 200 ns with FREQ_IN toggling -> all outputs 0, no PULSE. First rise after release produces no PULSE.
- 50% wave, 10 CLK high / 10 CLK low -> from second rise on, every PULSE shows TIME_HIGH=10, TIME_LOW=10, PERIOD=20, exactly one PULSE per 20 cycles.
- 1 kHz input at 50 MHz CLK, 25% duty -> TIME_HIGH=12500, TIME_LOW=37500, PERIOD=50000.
- Frequency step 20-cycle to 6-cycle (3/3) period -> second PULSE after the step reports 3/3/6. Outputs hold between pulses.
- FREQ_IN stuck high for 1000 cycles, then normal toggling -> no PULSE while stuck. The next PULSE reports TIME_HIGH≥1000, and later pulses return to the nominal values.
- RST_N pulsed low mid-high-phase -> outputs 0 immediately; first PULSE comes only after the second subsequent rise, with correct counts.

Source files
------------

// File: rtl/freq_counter.sv
// Measures high time, low time and period of FREQ_IN in CLK cycles; one PULSE per input period.
// Define FREQ_COUNTER_SYNC_EN to pass FREQ_IN through a 2-flop synchronizer (adds one cycle latency).
module freq_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FREQ_IN,
    output logic [WIDTH-1:0] TIME_HIGH,
    output logic [WIDTH-1:0] TIME_LOW,
    output logic [WIDTH-1:0] PERIOD,
    output logic             PULSE
);

    logic             s_q;
    logic             s_dly_q;
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] lo_cnt_q, lo_cnt_d;
    logic [WIDTH-1:0] time_high_q, time_high_d;
    logic [WIDTH-1:0] time_low_q, time_low_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             pulse_q, pulse_d;
    logic             armed_q, armed_d;
    logic             rise;
    logic [WIDTH:0]   sum;

`ifdef FREQ_COUNTER_SYNC_EN
    logic sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            sync_q <= FREQ_IN;
            s_q    <= sync_q;
        end
    end
`else
    // Source is already in the CLK domain: a single register is enough.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_q <= 1'b0;
        end else begin
            s_q <= FREQ_IN;
        end
    end
`endif

    assign rise = s_q & ~s_dly_q;
    assign sum  = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};

    always_comb begin
        hi_cnt_d    = hi_cnt_q;
        lo_cnt_d    = lo_cnt_q;
        time_high_d = time_high_q;
        time_low_d  = time_low_q;
        period_d    = period_q;
        pulse_d     = 1'b0;
        armed_d     = armed_q;
        if (rise) begin
            // The rise cycle itself is the first high cycle of the new period.
            hi_cnt_d = WIDTH'(1);
            lo_cnt_d = '0;
            armed_d  = 1'b1;
            if (armed_q) begin
                time_high_d = hi_cnt_q;
                time_low_d  = lo_cnt_q;
                period_d    = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                pulse_d     = 1'b1;
            end
        end else if (s_q) begin
            if (hi_cnt_q != '1) hi_cnt_d = hi_cnt_q + WIDTH'(1);
        end else begin
            if (lo_cnt_q != '1) lo_cnt_d = lo_cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_dly_q     <= 1'b0;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            time_high_q <= '0;
            time_low_q  <= '0;
            period_q    <= '0;
            pulse_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            s_dly_q     <= s_q;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            time_high_q <= time_high_d;
            time_low_q  <= time_low_d;
            period_q    <= period_d;
            pulse_q     <= pulse_d;
            armed_q     <= armed_d;
        end
    end

    assign TIME_HIGH = time_high_q;
    assign TIME_LOW  = time_low_q;
    assign PERIOD    = period_q;
    assign PULSE     = pulse_q;

endmodule

// File: tb/tb_freq_counter.sv
// Scoreboard bench for freq_counter: stimulus pushes expected results, a monitor pops them on PULSE.
module tb_freq_counter;

    logic        CLK;
    logic        RST_N;
    logic        FREQ_IN;
    logic [31:0] TIME_HIGH;
    logic [31:0] TIME_LOW;
    logic [31:0] PERIOD;
    logic        PULSE;

    freq_counter #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FREQ_IN   (FREQ_IN),
        .TIME_HIGH (TIME_HIGH),
        .TIME_LOW  (TIME_LOW),
        .PERIOD    (PERIOD),
        .PULSE     (PULSE)
    );

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic [31:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   have_prev = 0;
    int   prev_h    = 0;
    int   prev_l    = 0;

    logic [31:0] last_h = 0, last_l = 0, last_p = 0;
    logic        prev_pulse = 0;

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int h, input int l);
        exp_t e;
        e.h = h;
        e.l = l;
        e.p = h + l;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // n periods of h high / l low; each new rise reports the previous complete period
    task automatic run(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            if (have_prev != 0) push(prev_h, prev_l);
            $display("[TB] period high=%0d low=%0d", h, l);
            FREQ_IN = 1'b1;
            cyc(h);
            FREQ_IN = 1'b0;
            cyc(l);
            prev_h    = h;
            prev_l    = l;
            have_prev = 1;
        end
    endtask

    // Monitor: pops on PULSE, otherwise checks that outputs hold the last result
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            last_h = 0;
            last_l = 0;
            last_p = 0;
            chk("reset_pulse", {31'b0, PULSE}, 32'd0);
            chk("reset_period", PERIOD, 32'd0);
        end else if (PULSE) begin
            if (prev_pulse) chk("double_pulse", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {31'b0, PULSE}, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("[TB] pulse high=%0d low=%0d period=%0d (exp %0d/%0d/%0d)",
                         TIME_HIGH, TIME_LOW, PERIOD, e.h, e.l, e.p);
                chk("time_high", TIME_HIGH, e.h);
                chk("time_low", TIME_LOW, e.l);
                chk("period", PERIOD, e.p);
                last_h = e.h;
                last_l = e.l;
                last_p = e.p;
            end
        end else begin
            chk("hold_high", TIME_HIGH, last_h);
            chk("hold_low", TIME_LOW, last_l);
            chk("hold_period", PERIOD, last_p);
        end
        prev_pulse = PULSE;
    end

    initial begin
        RST_N   = 1'b0;
        FREQ_IN = 1'b0;
        // Reset held 200 ns with the input toggling
        for (int i = 0; i < 20; i++) begin
            #10 FREQ_IN = ~FREQ_IN;
        end
        chk("rst_time_high", TIME_HIGH, 32'd0);
        chk("rst_time_low", TIME_LOW, 32'd0);
        chk("rst_period", PERIOD, 32'd0);
        chk("rst_pulse", {31'b0, PULSE}, 32'd0);
        @(posedge CLK);
        #1;
        FREQ_IN = 1'b0;
        RST_N   = 1'b1;
        have_prev = 0;
        cyc(3);

        run(10, 10, 5);          // 50% wave
        run(12500, 37500, 1);    // 1 kHz at 50 MHz, 25% duty
        run(10, 10, 3);
        run(3, 3, 4);            // frequency step to 6-cycle period
        run(1000, 10, 1);        // stuck high for 1000 cycles
        run(10, 10, 3);          // back to nominal

        // Reset mid-high-phase
        if (have_prev != 0) push(prev_h, prev_l);
        FREQ_IN = 1'b1;
        cyc(5);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_time_high", TIME_HIGH, 32'd0);
        chk("async_rst_time_low", TIME_LOW, 32'd0);
        chk("async_rst_period", PERIOD, 32'd0);
        chk("async_rst_pulse", {31'b0, PULSE}, 32'd0);
        cyc(3);
        FREQ_IN   = 1'b0;
        RST_N     = 1'b1;
        have_prev = 0;
        cyc(4);
        run(7, 4, 3);

        // Final rise flushes the last complete period
        push(prev_h, prev_l);
        FREQ_IN = 1'b1;
        cyc(10);
        FREQ_IN = 1'b0;
        cyc(5);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
